instr_encoder_loader: RTL and testbench

- Sequential writer for instruction memory; the inverse of the instruction field decoder.
- Accepts R/I/J field bundles over a valid/ready handshake and packs each into a 32-bit MIPS word.
- Writes words to consecutive instruction-memory word addresses from a programmed base.
- Used by the testbench/boot path to load programs into IMEM before the single-cycle core runs.

---
 rtl/instr_encoder_loader.sv | 119 +++++++++++
 tb/tb_instr_encoder_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Sequential instruction-memory loader: packs R/I/J field bundles into 32-bit
// MIPS words and writes them to consecutive IMEM word addresses.
module instr_encoder_loader #(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_words,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        fmt,
   input  logic [5:0]        opcode,
   input  logic [5:0]        funct,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [4:0]        shamt,
   input  logic [15:0]       imm,
   input  logic [25:0]       addr_j,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              load_done,
   output logic [7:0]        err_cnt
);

   typedef enum logic [1:0] {IDLE, LOAD, LAST} state_t;

   state_t            state;
   logic [CNT_W-1:0]  target_cnt;
   logic [CNT_W-1:0]  accept_cnt;
   logic [CNT_W-1:0]  accept_cnt_nxt;
   logic [ADDR_W-1:0] next_addr;
   logic [31:0]       enc_word;

   assign accept_cnt_nxt = accept_cnt + CNT_W'(1);

   // R-format always carries a zero opcode regardless of the opcode input.
   always_comb begin
      enc_word = 32'd0;
      case (fmt)
         2'd0:    enc_word = {6'b0, rs, rt, rd, shamt, funct};
         2'd1:    enc_word = {opcode, rs, rt, imm};
         2'd2:    enc_word = {opcode, addr_j};
         default: enc_word = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 32'd0;
         busy       <= 1'b0;
         load_done  <= 1'b0;
         err_cnt    <= 8'd0;
         target_cnt <= '0;
         accept_cnt <= '0;
         next_addr  <= '0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  target_cnt <= num_words;
                  accept_cnt <= '0;
                  next_addr  <= base_addr;
                  err_cnt    <= 8'd0;
                  busy       <= 1'b1;
                  if (num_words == '0) begin
                     state     <= LAST;
                     load_done <= 1'b1;
                  end else begin
                     state    <= LOAD;
                     in_ready <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (in_valid) begin
                  accept_cnt <= accept_cnt_nxt;
                  // Illegal bundles use up a slot but leave the address untouched.
                  if (fmt != 2'd3) begin
                     wr_en     <= 1'b1;
                     wr_addr   <= next_addr;
                     wr_data   <= enc_word;
                     next_addr <= next_addr + ADDR_W'(1);
                  end else if (err_cnt != 8'hFF) begin
                     err_cnt <= err_cnt + 8'd1;
                  end
                  if (accept_cnt_nxt == target_cnt) begin
                     state     <= LAST;
                     in_ready  <= 1'b0;
                     load_done <= 1'b1;
                  end
               end
            end
            LAST: begin
               state     <= IDLE;
               load_done <= 1'b0;
               busy      <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               load_done <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with a write scoreboard checked by
// immediate assertions on the falling clock edge.
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  base_addr;
   logic [8:0]  num_words;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  fmt;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic [25:0] addr_j;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic        load_done;
   logic [7:0]  err_cnt;

   int          checks   = 0;
   int          errors   = 0;
   int          wr_count = 0;
   logic [39:0] exp_q[$];
   logic [7:0]  exp_addr;

   instr_encoder_loader #(.ADDR_W(8), .CNT_W(9)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .num_words(num_words), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
      .shamt(shamt), .imm(imm), .addr_j(addr_j), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
      .load_done(load_done), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Every write strobe is matched against the oldest expected {addr,data}.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wr_count++;
         if (exp_q.size() == 0) begin
            check("unexpected_write", {wr_addr, wr_data}, 40'hXXXXXXXXXX);
         end else begin
            check("write", {wr_addr, wr_data}, exp_q.pop_front());
         end
      end
   end

   task automatic do_start(input logic [7:0] base, input logic [8:0] n);
      @(negedge clk);
      start     = 1'b1;
      base_addr = base;
      num_words = n;
      exp_addr  = base;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drive(input logic [1:0] f, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                        input logic [4:0] sh, input logic [15:0] im, input logic [25:0] aj);
      fmt = f; opcode = op; funct = fn; rs = s; rt = t; rd = d;
      shamt = sh; imm = im; addr_j = aj;
      in_valid = 1'b1;
   endtask

   task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic [4:0] sh, input logic [15:0] im, input logic [25:0] aj,
                       input logic legal, input logic [31:0] exp_data);
      int waited = 0;
      drive(f, op, fn, s, t, d, sh, im, aj);
      while (in_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (in_ready !== 1'b1) begin
         check("in_ready_timeout", {39'd0, in_ready}, 40'd1);
         in_valid = 1'b0;
         return;
      end
      if (legal) begin
         exp_q.push_back({exp_addr, exp_data});
         exp_addr = exp_addr + 8'd1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; in_valid = 1'b0;
      drive(2'd0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
      in_valid = 1'b0;
      exp_addr = '0;
      @(negedge clk);
      check("reset_outputs", {wr_en, in_ready, busy, load_done, wr_addr, wr_data},
            {1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0});
      check("reset_err_cnt", {32'd0, err_cnt}, 40'd0);
      rst_n = 1'b1;

      // in_valid while idle is ignored
      drive(2'd0, 6'd0, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
      @(negedge clk);
      @(negedge clk);
      check("idle_in_ready", {38'd0, in_ready, busy}, 40'd0);
      in_valid = 1'b0;

      // basic R/I/J load
      do_start(8'h10, 9'd3);
      check("load_busy", {38'd0, busy, in_ready}, 40'd3);
      send(2'd0, 6'd0,    6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0,    1'b1, 32'h00221820);
      send(2'd1, 6'h08,   6'd0,  5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'd0,    1'b1, 32'h2022FFFF);
      send(2'd2, 6'h02,   6'd0,  5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h40,   1'b1, 32'h08000040);
      in_valid = 1'b0;
      check("t1_last", {36'd0, load_done, wr_en, busy, in_ready}, 40'hE);
      @(negedge clk);
      check("t1_after", {37'd0, load_done, busy, wr_en}, 40'd0);
      check("t1_err_cnt", {32'd0, err_cnt}, 40'd0);

      // R ignores opcode input
      do_start(8'h20, 9'd1);
      send(2'd0, 6'h3F, 6'h08, 5'd31, 5'd0, 5'd0, 5'd0, 16'h0000, 26'd0, 1'b1, 32'h03E00008);
      in_valid = 1'b0;
      check("t2_done", {38'd0, load_done, wr_en}, 40'd3);

      // address wrap
      do_start(8'hFE, 9'd3);
      send(2'd1, 6'h0C, 6'd0,  5'd3, 5'd4, 5'd0, 5'd0, 16'h1234, 26'd0,        1'b1, 32'h30641234);
      send(2'd2, 6'h03, 6'd0,  5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h3FFFFFF,  1'b1, 32'h0FFFFFFF);
      send(2'd0, 6'd0,  6'h00, 5'd0, 5'd0, 5'd5, 5'd2, 16'h0000, 26'd0,        1'b1, 32'h00002880);
      in_valid = 1'b0;
      check("t3_done", {38'd0, load_done, wr_en}, 40'd3);

      // illegal bundle consumes a slot but does not write
      do_start(8'h40, 9'd2);
      send(2'd3, 6'h11, 6'h22, 5'd1, 5'd1, 5'd1, 5'd1, 16'hAAAA, 26'd5, 1'b0, 32'd0);
      check("t4_after_illegal", {37'd0, load_done, wr_en, busy}, 40'd1);
      check("t4_err_mid", {32'd0, err_cnt}, 40'd1);
      send(2'd1, 6'h23, 6'd0,  5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'd0, 1'b1, 32'h8FA80004);
      in_valid = 1'b0;
      check("t4_done", {38'd0, load_done, wr_en}, 40'd3);
      @(negedge clk);
      check("t4_err_cnt", {32'd0, err_cnt}, 40'd1);

      // reset between accept and its write
      do_start(8'h50, 9'd4);
      drive(2'd0, 6'd0, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("t6_reset_outputs", {wr_en, in_ready, busy, load_done, wr_addr, wr_data},
            {1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0});
      check("t6_reset_err_cnt", {32'd0, err_cnt}, 40'd0);
      rst_n = 1'b1;
      @(negedge clk);
      do_start(8'h60, 9'd1);
      send(2'd2, 6'h02, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h123, 1'b1, 32'h08000123);
      in_valid = 1'b0;
      check("t6_restart_done", {38'd0, load_done, wr_en}, 40'd3);

      // zero-length load
      do_start(8'h70, 9'd0);
      check("t5_last", {36'd0, load_done, busy, wr_en, in_ready}, 40'hC);
      @(negedge clk);
      check("t5_after", {38'd0, load_done, busy}, 40'd0);

      @(negedge clk);
      check("total_writes", 40'(wr_count), 40'd9);
      check("queue_empty", 40'(exp_q.size()), 40'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
